adder_rr_scheduler: RTL

Round-robin scheduler that shares one 16-bit pipelined adder (3-cycle latency, no enable, no reset) among N requesters. Each cycle it accepts at most one request, drives the operands into the adder, and tracks the requester ID alongside the adder pipeline. It returns each sum/carry-out with the ID of the requester that issued it. It sits between the requesting engines and the adder instance, and is the only block that drives the adder's inputs.

---
 rtl/adder_rr_scheduler.sv | 105 ++++++++++
 1 files changed

// File: rtl/adder_rr_scheduler.sv
// Round-robin front end for a shared 3-stage 16-bit adder: grants one requester per cycle,
// registers its operands into the adder and carries the requester ID alongside the adder pipeline.
module adder_rr_scheduler #(
    parameter int N       = 4,
    parameter int ID_W    = $clog2(N),
    parameter int ADD_LAT = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              issue_en_i,
    input  logic [N-1:0]      req_valid_i,
    input  logic [16*N-1:0]   req_a_i,
    input  logic [16*N-1:0]   req_b_i,
    input  logic [N-1:0]      req_cin_i,
    output logic [N-1:0]      req_ready_o,
    output logic [15:0]       add_a_o,
    output logic [15:0]       add_b_o,
    output logic              add_cin_o,
    input  logic [15:0]       add_sum_i,
    input  logic              add_cout_i,
    output logic              rsp_valid_o,
    output logic [ID_W-1:0]   rsp_id_o,
    output logic [15:0]       rsp_sum_o,
    output logic              rsp_cout_o,
    output logic              busy_o,
    output logic [15:0]       op_count_o
);

    logic [ID_W-1:0]              last_q, last_d;
    logic [15:0]                  add_a_q, add_b_q;
    logic                         add_cin_q;
    logic [ADD_LAT:0]             tag_vld_q;
    logic [ADD_LAT:0][ID_W-1:0]   tag_id_q;
    logic                         rsp_valid_q, rsp_cout_q;
    logic [ID_W-1:0]              rsp_id_q;
    logic [15:0]                  rsp_sum_q;
    logic [15:0]                  op_count_q, op_count_d;

    logic                         accept;
    logic [ID_W-1:0]              win_id;
    int                           idx;

    // Search begins one past the last winner and wraps, so every requester gets a turn.
    always_comb begin
        accept = 1'b0;
        win_id = '0;
        idx    = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_q) + k) % N;
            if (!accept && req_valid_i[idx] && issue_en_i && !rst_i) begin
                accept = 1'b1;
                win_id = ID_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (accept) req_ready_o[win_id] = 1'b1;
        last_d     = accept ? win_id : last_q;
        op_count_d = accept ? op_count_q + 16'd1 : op_count_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q      <= ID_W'(N - 1);
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            op_count_q  <= '0;
        end else begin
            last_q     <= last_d;
            op_count_q <= op_count_d;
            // Idle cycles feed zeros so the adder never sees a stale operand pair.
            add_a_q    <= accept ? req_a_i[16*win_id +: 16] : 16'd0;
            add_b_q    <= accept ? req_b_i[16*win_id +: 16] : 16'd0;
            add_cin_q  <= accept ? req_cin_i[win_id] : 1'b0;
            tag_vld_q  <= {tag_vld_q[ADD_LAT-1:0], accept};
            tag_id_q   <= {tag_id_q[ADD_LAT-1:0], win_id};
            rsp_valid_q <= tag_vld_q[ADD_LAT];
            if (tag_vld_q[ADD_LAT]) begin
                rsp_id_q   <= tag_id_q[ADD_LAT];
                rsp_sum_q  <= add_sum_i;
                rsp_cout_q <= add_cout_i;
            end
        end
    end

    assign add_a_o     = add_a_q;
    assign add_b_o     = add_b_q;
    assign add_cin_o   = add_cin_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_sum_o   = rsp_sum_q;
    assign rsp_cout_o  = rsp_cout_q;
    assign op_count_o  = op_count_q;
    assign busy_o      = (|tag_vld_q) | rsp_valid_q;

endmodule
